// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared states and sizing for the 8:1 mux scan sequencer.
package mux_seq_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
    localparam int N_CH     = 8;
    localparam int SEL_W    = 3;
    localparam int HOLD_MAX = 16;
endpackage

// File: rtl/mux_seq_hold_cnt.sv
// mux_seq_hold_cnt: 4-bit hold counter that wraps at HOLD-1 and flags terminal count.
module mux_seq_hold_cnt #(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [3:0] cnt_q, cnt_d;
    assign tc_o  = cnt_q == 4'(HOLD - 1);
    assign cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 4'd1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: latches a word onto the 8:1 mux inputs, walks the selects
// through every channel and reassembles the sampled mux output.
module mux_scan_sequencer
    import mux_seq_pkg::*;
#(
    parameter bit LSB_FIRST   = 1'b1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [N_CH-1:0] data_in_i,
    output logic [N_CH-1:0] i_bus_o,
    output logic            s2_o,
    output logic            s1_o,
    output logic            s0_o,
    input  logic            y_in_i,
    output logic            ser_out_o,
    output logic            ser_valid_o,
    output logic [N_CH-1:0] word_out_o,
    output logic            done_o,
    output logic            mismatch_o,
    output logic            busy_o
);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] SEL_FIRST = LSB_FIRST ? '0 : SEL_LAST;

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
        $error("mux_scan_sequencer: HOLD_CYCLES must be 1..16");
    end

    state_e           state_q, state_d;
    logic [N_CH-1:0]  ibus_q, ibus_d, word_q, word_d;
    logic [SEL_W-1:0] sel_q, sel_d, idx_q, idx_d;
    logic             ser_q, ser_d, sv_q, sv_d, mis_q, mis_d;
    logic             tc;

    mux_seq_hold_cnt #(.HOLD(HOLD_CYCLES)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != SCAN),
        .en_i  (state_q == SCAN),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        ibus_d  = ibus_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        word_d  = word_q;
        ser_d   = ser_q;
        sv_d    = 1'b0;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SCAN;
                ibus_d  = data_in_i;
                sel_d   = SEL_FIRST;
                idx_d   = '0;
                word_d  = '0;
            end
            SCAN: if (tc) begin
                ser_d         = y_in_i;
                word_d[sel_q] = y_in_i;
                sv_d          = 1'b1;
                // the step after the final sample is suppressed so sel parks on the last channel
                if (idx_q == SEL_LAST) begin
                    state_d = DONE;
                    mis_d   = word_d != ibus_q;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                    sel_d = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ibus_q  <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            ser_q   <= 1'b0;
            sv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ibus_q  <= ibus_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            ser_q   <= ser_d;
            sv_q    <= sv_d;
            mis_q   <= mis_d;
        end
    end

    assign i_bus_o            = ibus_q;
    assign {s2_o, s1_o, s0_o} = sel_q;
    assign ser_out_o          = ser_q;
    assign ser_valid_o        = sv_q;
    assign word_out_o         = word_q;
    assign done_o             = state_q == DONE;
    assign mismatch_o         = mis_q;
    assign busy_o             = state_q != IDLE;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: two sequencer configurations, each closing the loop through an
// 8:1 mux with an optional stuck-at-0 channel, checked against a cycle-offset model.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] st, s2, s1, s0, y, ser, sv, dn, mis, bs;
    logic [7:0] din [2];
    logic [7:0] ibus [2];
    logic [7:0] wo [2];
    int kill [2];
    int hp [2] = '{1, 3};
    int lp [2] = '{1, 0};
    int errs = 0, checks = 0;

    for (genvar j = 0; j < 2; j++) begin : g_mux
        wire [2:0] sl = {s2[j], s1[j], s0[j]};
        assign y[j] = (kill[j] == int'(sl)) ? 1'b0 : ibus[j][sl];
    end

    mux_scan_sequencer #(.LSB_FIRST(1'b1), .HOLD_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(st[0]), .data_in_i(din[0]), .i_bus_o(ibus[0]),
        .s2_o(s2[0]), .s1_o(s1[0]), .s0_o(s0[0]), .y_in_i(y[0]), .ser_out_o(ser[0]),
        .ser_valid_o(sv[0]), .word_out_o(wo[0]), .done_o(dn[0]), .mismatch_o(mis[0]), .busy_o(bs[0])
    );
    mux_scan_sequencer #(.LSB_FIRST(1'b0), .HOLD_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(st[1]), .data_in_i(din[1]), .i_bus_o(ibus[1]),
        .s2_o(s2[1]), .s1_o(s1[1]), .s0_o(s0[1]), .y_in_i(y[1]), .ser_out_o(ser[1]),
        .ser_valid_o(sv[1]), .word_out_o(wo[1]), .done_o(dn[1]), .mismatch_o(mis[1]), .busy_o(bs[1])
    );

    task automatic chk(input string nm, input int j, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, j, $time, act, exp);
        end
    endtask

    function automatic int chan(int j, int m);
        return lp[j] != 0 ? m : 7 - m;
    endfunction

    // t = cycles since start acceptance (0 = idle); outputs derived from the timing rules
    int t [2];
    logic [7:0] mw [2];
    logic [7:0] macc [2];
    logic [7:0] msel [2];
    logic mser [2], msv [2], mmis [2];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                t[j] = 0; mw[j] = 0; macc[j] = 0; msel[j] = 0; mser[j] = 0; msv[j] = 0; mmis[j] = 0;
            end else begin
                if (t[j] == 0) begin
                    if (st[j]) begin t[j] = 1; mw[j] = din[j]; macc[j] = 0; end
                end else if (t[j] == 8 * hp[j] + 1) t[j] = 0;
                else t[j]++;
                msv[j] = 0;
                if (t[j] >= 1 && t[j] <= 8 * hp[j]) msel[j] = 8'(chan(j, (t[j] - 1) / hp[j]));
                if (t[j] >= 2 && (t[j] - 1) % hp[j] == 0) begin
                    int m, c;
                    m = (t[j] - 1) / hp[j] - 1;
                    c = chan(j, m);
                    mser[j] = (kill[j] == c) ? 1'b0 : mw[j][c];
                    macc[j][c] = mser[j];
                    msv[j] = 1;
                    if (m == 7) mmis[j] = macc[j] != mw[j];
                end
            end
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("i_bus", j, ibus[j], mw[j]);
            chk("sel", j, {5'd0, s2[j], s1[j], s0[j]}, msel[j]);
            chk("ser_out", j, 8'(ser[j]), 8'(mser[j]));
            chk("ser_valid", j, 8'(sv[j]), 8'(msv[j]));
            chk("word_out", j, wo[j], macc[j]);
            chk("done", j, 8'(dn[j]), 8'(t[j] == 8 * hp[j] + 1));
            chk("mismatch", j, 8'(mis[j]), 8'(mmis[j]));
            chk("busy", j, 8'(bs[j]), 8'(t[j] != 0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq;
        int nd, ni, seen;
        st = 0; din[0] = 0; din[1] = 0; kill[0] = -1; kill[1] = -1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 8'(bs[0]), 8'h0);
        chk("rst_word", 1, wo[1], 8'h00);
        rst_n = 1;
        @(negedge clk);
        // LSB-first H=1 on A alongside MSB-first H=3 on B
        st = 2'b11; din[0] = 8'hA5; din[1] = 8'h3C; seq = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            st = 0;
            if (c >= 2 && c <= 9) seq[c - 2] = ser[0];
            if (c == 1) chk("b_first_sel", 1, {5'd0, s2[1], s1[1], s0[1]}, 8'd7);
            if (c == 4) chk("b_second_sel", 1, {5'd0, s2[1], s1[1], s0[1]}, 8'd6);
            if (c == 2) chk("a_first_valid", 0, 8'(sv[0]), 8'h1);
            if (c == 9) begin
                chk("a_done", 0, 8'(dn[0]), 8'h1);
                chk("a_word", 0, wo[0], 8'hA5);
                chk("a_mis", 0, 8'(mis[0]), 8'h0);
            end
            if (c == 24) chk("b_early_done", 1, 8'(dn[1]), 8'h0);
            if (c == 25) begin
                chk("b_done", 1, 8'(dn[1]), 8'h1);
                chk("b_word", 1, wo[1], 8'h3C);
            end
            if (c == 26) chk("b_idle", 1, 8'(bs[1]), 8'h0);
        end
        chk("a_serial", 0, seq, 8'hA5);
        // stuck-at-0 on channel 5
        kill[0] = 5; st[0] = 1; din[0] = 8'hFF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            st[0] = 0;
            if (c == 9) begin
                chk("fault_word", 0, wo[0], 8'hDF);
                chk("fault_mis", 0, 8'(mis[0]), 8'h1);
            end
        end
        kill[0] = -1;
        // starts during SCAN and DONE are ignored; one right after DONE is taken
        st[0] = 1; din[0] = 8'hA5;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            st[0] = 0;
            if (c == 9) chk("busy_word", 0, wo[0], 8'hA5);
            if (c == 11) begin
                chk("restart_busy", 0, 8'(bs[0]), 8'h1);
                chk("restart_ibus", 0, ibus[0], 8'h5A);
            end
            if (c == 3 || c == 9 || c == 10) begin
                st[0] = 1;
                din[0] = (c == 10) ? 8'h5A : 8'h00;
            end
        end
        // asynchronous abort mid-scan
        st = 2'b11; din[0] = 8'hC3; din[1] = 8'h81;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            st = 0;
        end
        rst_n = 0;
        #1;
        chk("abort_busy", 0, 8'(bs[0]), 8'h0);
        chk("abort_ibus", 0, ibus[0], 8'h00);
        chk("abort_word", 0, wo[0], 8'h00);
        chk("abort_b_busy", 1, 8'(bs[1]), 8'h0);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen += int'(dn[0]) + int'(dn[1]) + int'(sv[0]) + int'(sv[1]);
        end
        chk("abort_quiet", 0, 8'(seen), 8'h0);
        rst_n = 1;
        @(negedge clk);
        st[0] = 1; din[0] = 8'h96;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            st[0] = 0;
            if (c == 9) chk("after_abort_word", 0, wo[0], 8'h96);
        end
        // start held high: one idle cycle between scans
        st[0] = 1; din[0] = 8'h3C; nd = 0; ni = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            nd += int'(dn[0]);
            ni += int'(!bs[0]);
            if (c == 19) chk("b2b_done19", 0, 8'(dn[0]), 8'h1);
            if (c == 30) st[0] = 0;
        end
        chk("b2b_dones", 0, 8'(nd), 8'd3);
        chk("b2b_idles", 0, 8'(ni), 8'd3);
        repeat (12) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
